// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-ported memory, one transaction in flight.
// Define ARB_RR_EN to replace fixed data-port priority with alternation between contending requesters.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic                dm_gnt_o,
  output logic                dm_rvalid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o,
  output logic                proto_err_o
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              owner_if_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;

  logic              if_rvalid_q, dm_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              proto_err_q;

  logic any_req;
  logic pick_if;
  logic latch_en;
  logic resp_fire;

  assign any_req   = if_req_i | dm_req_i;
  assign resp_fire = (state_q == WAIT) & mem_rvalid_i;
  assign latch_en  = any_req & ((state_q == IDLE) | resp_fire);

`ifdef ARB_RR_EN
  logic last_owner_if_q;

  // On contention the requester that did not win last time goes first
  always_comb begin
    pick_if = if_req_i & (~dm_req_i | ~last_owner_if_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_owner_if_q <= 1'b0;
    end else if (latch_en) begin
      last_owner_if_q <= pick_if;
    end
  end
`else
  always_comb begin
    pick_if = if_req_i & ~dm_req_i;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (mem_gnt_i) state_d = WAIT;
      WAIT:    if (mem_rvalid_i) state_d = any_req ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if_gnt_o    = 1'b0;
    dm_gnt_o    = 1'b0;
    busy_o      = (state_q != IDLE);
    if (state_q == ISSUE) begin
      mem_req_o   = 1'b1;
      mem_we_o    = we_q;
      mem_be_o    = be_q;
      mem_addr_o  = addr_q;
      mem_wdata_o = wdata_q;
      if_gnt_o    = mem_gnt_i & owner_if_q;
      dm_gnt_o    = mem_gnt_i & ~owner_if_q;
    end
  end

  // Fetches are captured as full-word reads regardless of the data-port fields
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner_if_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
    end else if (latch_en) begin
      owner_if_q <= pick_if;
      if (pick_if) begin
        addr_q  <= if_addr_i;
        we_q    <= 1'b0;
        be_q    <= '1;
        wdata_q <= '0;
      end else begin
        addr_q  <= dm_addr_i;
        we_q    <= dm_we_i;
        be_q    <= dm_be_i;
        wdata_q <= dm_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= resp_fire & owner_if_q;
      dm_rvalid_q <= resp_fire & ~owner_if_q;
      if (resp_fire & owner_if_q) if_rdata_q <= mem_rdata_i;
      if (resp_fire & ~owner_if_q) dm_rdata_q <= mem_rdata_i;
    end
  end

  // A response outside WAIT has no owner; it is dropped and flagged until reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      proto_err_q <= 1'b0;
    end else if (mem_rvalid_i && (state_q != WAIT)) begin
      proto_err_q <= 1'b1;
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign proto_err_o = proto_err_q;

endmodule
